// File: rtl/comparator_serial_if.sv
// Handshake/operand bundle for the digit-serial magnitude comparator.
interface comparator_serial_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             signed_mode;
  logic             l;
  logic             e;
  logic             g;
  logic             busy;
  logic             done;
  logic             lt;
  logic             eq;
  logic             gt;

  modport master (
    output start, A, B, signed_mode, l, e, g,
    input  busy, done, lt, eq, gt
  );

  modport slave (
    input  start, A, B, signed_mode, l, e, g,
    output busy, done, lt, eq, gt
  );
endinterface

// File: rtl/comparator_serial.sv
// Digit-serial magnitude comparator: walks the operands DIGIT bits per cycle,
// LSB slice first, so the most significant differing slice decides last.
module comparator_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic          clk,
  input logic          rst_n,
  comparator_serial_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {R_EQ, R_LT, R_GT} res_t;

  state_t           state_q, state_d;
  logic             armed_q, armed_d;   // start accepted, RUN begins next edge
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sgn_q, sgn_d;
  res_t             res_q, res_d;
  logic             lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;

  res_t             seed;
  res_t             res_nxt;
  logic [DIGIT-1:0] sa, sb;
  logic             accept;

  // Seed normalisation: equal wins, then less, then greater, else equal
  always_comb begin
    seed = R_EQ;
    if (bus.e)      seed = R_EQ;
    else if (bus.l) seed = R_LT;
    else if (bus.g) seed = R_GT;
  end

  // Compare the current low slice; the top slice gets its sign bit flipped
  // in signed mode so two's-complement order maps onto unsigned order
  always_comb begin
    sa = a_q[DIGIT-1:0];
    sb = b_q[DIGIT-1:0];
    if (sgn_q && (cnt_q == LAST)) begin
      sa[DIGIT-1] = ~sa[DIGIT-1];
      sb[DIGIT-1] = ~sb[DIGIT-1];
    end
    res_nxt = res_q;
    if (sa > sb)      res_nxt = R_GT;
    else if (sa < sb) res_nxt = R_LT;
  end

  assign accept = bus.start && !armed_q && ((state_q == IDLE) || (state_q == DONE));

  // Next-state, datapath and result-flag update
  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    res_d   = res_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    case (state_q)
      IDLE: begin
        if (armed_q) begin
          state_d = RUN;
          armed_d = 1'b0;
        end
      end
      RUN: begin
        res_d = res_nxt;
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          lt_d    = (res_nxt == R_LT);
          eq_d    = (res_nxt == R_EQ);
          gt_d    = (res_nxt == R_GT);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      a_d     = bus.A;
      b_d     = bus.B;
      sgn_d   = bus.signed_mode;
      res_d   = seed;
      cnt_d   = '0;
      armed_d = 1'b1;
      state_d = IDLE;
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      res_q   <= R_EQ;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      res_q   <= res_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.lt   = lt_q;
  assign bus.eq   = eq_q;
  assign bus.gt   = gt_q;
endmodule

// File: doc/comparator_serial.md
COMPARATOR_SERIAL -- requirements
Module: comparator_serial

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be a positive multiple of DIGIT.
REQ-002 Parameter DIGIT, default 4, bits compared per clock cycle; SHALL be >= 1.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 start  input  1  request to begin a comparison; sampled only when the block accepts (REQ-012).
REQ-006 A  input  WIDTH  first operand, captured on accepted start.
REQ-007 B  input  WIDTH  second operand, captured on accepted start.
REQ-008 signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; captured on accepted start.
REQ-009 l, e, g  input  1 each  cascade seed from a lower-order comparator; captured on accepted start.
REQ-010 busy  output  1  high while a comparison is in progress.
REQ-011 done, lt, eq, gt  output  1 each  done = one-cycle completion pulse; lt/eq/gt = registered result flags.

Function
REQ-012 States: IDLE, RUN, DONE; start SHALL be accepted in IDLE or DONE and ignored in RUN.
REQ-013 Accepted start SHALL capture A, B, signed_mode and the normalised seed, clear the digit counter, and enter RUN on the next edge.
REQ-014 Seed normalisation SHALL be: e=1 -> EQ; else l=1 -> LT; else g=1 -> GT; else EQ.
REQ-015 RUN SHALL process one DIGIT-bit slice per cycle, LSB slice first, for exactly N = WIDTH/DIGIT cycles.
REQ-016 Per slice: A-slice > B-slice -> running result GT; A-slice < B-slice -> running result LT; equal -> running result unchanged.
REQ-017 When signed_mode = 1, the most-significant slice SHALL be compared with its top bit of A and B inverted; all other slices SHALL be compared unsigned.
REQ-018 After slice N-1, the FSM SHALL enter DONE; lt/eq/gt SHALL be updated from the running result on that same edge and be one-hot.
REQ-019 done SHALL be high for exactly the one cycle spent in DONE; DONE SHALL return to IDLE on the next edge unless start is accepted.
REQ-020 Latency: start sampled high at edge k -> done high in the cycle after edge k+N+1; back-to-back start in DONE SHALL produce a gap-free cadence of N+2 cycles.
REQ-021 lt/eq/gt SHALL hold their last result through IDLE and RUN until the next DONE; they SHALL NOT show intermediate values.
REQ-022 busy SHALL be high in RUN only.
REQ-023 Input changes on A, B, signed_mode, l, e, g while busy SHALL NOT affect the result in progress.
REQ-024 DIGIT = WIDTH (N = 1) SHALL be supported: one RUN cycle.

Reset
REQ-025 rst_n = 0 at a rising edge SHALL force IDLE and clear the counter; busy = 0, done = 0, lt = 0, eq = 0, gt = 0.
REQ-026 Reset asserted during RUN or DONE SHALL abort the comparison; no done pulse SHALL follow.
REQ-027 start sampled in the same cycle as rst_n = 0 SHALL be ignored.

Verification (WIDTH = 16, DIGIT = 4, N = 4)
REQ-028 A = 0x1234, B = 0x1234, unsigned, seed e = 1 -> busy for 4 cycles, then done pulse with eq = 1.
REQ-029 Same operands, seed l = 1, e = 0 -> lt = 1; seed all zero -> eq = 1.
REQ-030 A = 0x8000, B = 0x0001: unsigned -> gt = 1; signed -> lt = 1.
REQ-031 A = 0x0005, B = 0x0003, seed l = 1 -> gt = 1, because a slice difference overrides the seed.
REQ-032 start pulsed again during RUN with different operands -> ignored; first result delivered unchanged. start held in DONE -> next done exactly 6 cycles later.
REQ-033 rst_n low for one cycle at RUN cycle 2 -> all outputs 0 the next cycle and no done pulse; a subsequent start completes normally.
